// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH stream demux with a one-word holding register per output channel.
// Optional broadcast input `in_bcast` is enabled by defining DEMUX_BCAST_EN.
module stream_demux #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned SEL_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [SEL_W-1:0]         in_sel,
`ifdef DEMUX_BCAST_EN
   input  logic                     in_bcast,
`endif
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [7:0]               drop_cnt
);

   // One extra bit so NUM_CH == 2**SEL_W still compares correctly.
   localparam logic [SEL_W:0] NumChW = (SEL_W+1)'(NUM_CH);

   logic                     bcast;
   logic                     sel_ok;
   logic                     in_fire;
   logic [NUM_CH-1:0]        sel_hit;
   logic [NUM_CH-1:0]        chan_free;
   logic [NUM_CH-1:0]        load;
   logic [NUM_CH-1:0]        valid_d, valid_q;
   logic [NUM_CH*DATA_W-1:0] data_d, data_q;
   logic [7:0]               drop_d, drop_q;

`ifdef DEMUX_BCAST_EN
   assign bcast = in_bcast;
`else
   assign bcast = 1'b0;
`endif

   always_comb begin
      sel_ok = ({1'b0, in_sel} < NumChW);
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         sel_hit[k]   = (in_sel == SEL_W'(k));
         chan_free[k] = !valid_q[k] || out_ready[k];
      end

      if (bcast) begin
         in_ready = &chan_free;
      end else if (sel_ok) begin
         in_ready = |(sel_hit & chan_free);
      end else begin
         in_ready = 1'b1;
      end

      in_fire = in_valid && in_ready;
      if (!in_fire) begin
         load = '0;
      end else if (bcast) begin
         load = '1;
      end else begin
         load = sel_hit;
      end

      // A drained channel clears unless it reloads in the same cycle.
      valid_d = (valid_q & ~out_ready) | load;

      data_d = data_q;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (load[k]) begin
            data_d[k*DATA_W +: DATA_W] = in_data;
         end
      end

      drop_d = drop_q;
      if (in_fire && !bcast && !sel_ok && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
         drop_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         drop_q  <= drop_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign drop_cnt  = drop_q;

endmodule
